// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request/response bundle between a core-side
// load/store controller (master) and the data-memory responder (slave).
//   req_valid   request present              (master -> slave)
//   req_ready   responder can accept         (slave -> master)
//   address     byte address                 (master -> slave)
//   read/write  load / store strobes         (master -> slave)
//   maskByte    store byte-lane enables      (master -> slave)
//   dataMemIn   lane-aligned store data      (master -> slave)
//   rsp_valid   one-cycle completion pulse   (slave -> master)
//   rsp_error   request rejected             (slave -> master)
//   dataMemOut  aligned read word            (slave -> master)
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  maskByte;
  logic [31:0] dataMemIn;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] dataMemOut;

  modport master (
    output req_valid, address, read, write, maskByte, dataMemIn,
    input  req_ready, rsp_valid, rsp_error, dataMemOut
  );

  modport slave (
    input  req_valid, address, read, write, maskByte, dataMemIn,
    output req_ready, rsp_valid, rsp_error, dataMemOut
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder.
// Accepts one request in IDLE, waits WAIT_STATES cycles, commits a byte-masked
// store or fetches the aligned word for a load, then pulses rsp_valid for one
// cycle. Out-of-range addresses and read&write requests complete with rsp_error.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    data_mem_responder_if slave modport (request + response signals)
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] word_q;
  logic                  write_q;
  logic [3:0]            mask_q;
  logic [31:0]           data_q;
  logic                  err_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [31:0]           rdata_q;

  logic [31:0] mem [Depth];

  logic accept;
  logic req_err;
  assign accept  = bus.req_valid && (state_q == StIdle) && (bus.read || bus.write);
  assign req_err = (bus.read && bus.write) || ((bus.address >> (ADDR_WIDTH + 2)) != '0);

  // With no wait states the commit happens on the acceptance edge, so it must
  // use the live request; otherwise it uses the copy captured at acceptance.
  logic                  commit_en;
  logic                  commit_write;
  logic                  commit_err;
  logic [ADDR_WIDTH-1:0] commit_word;
  logic [3:0]            commit_mask;
  logic [31:0]           commit_data;

  always_comb begin
    if (WAIT_STATES == 0) begin
      commit_en    = accept;
      commit_write = bus.write;
      commit_err   = req_err;
      commit_word  = bus.address[ADDR_WIDTH+1:2];
      commit_mask  = bus.maskByte;
      commit_data  = bus.dataMemIn;
    end else begin
      commit_en    = (state_q == StWait) && (cnt_q == '0);
      commit_write = write_q;
      commit_err   = err_q;
      commit_word  = word_q;
      commit_mask  = mask_q;
      commit_data  = data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      word_q      <= '0;
      write_q     <= 1'b0;
      mask_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Entering RESP coincides exactly with the commit edge.
      rsp_valid_q <= (state_d == StResp);
      rsp_error_q <= (state_d == StResp) && commit_err;
      if (accept) begin
        word_q  <= bus.address[ADDR_WIDTH+1:2];
        write_q <= bus.write;
        mask_q  <= bus.maskByte;
        data_q  <= bus.dataMemIn;
        err_q   <= req_err;
      end
      if (commit_en) begin
        if (commit_err) begin
          rdata_q <= '0;
        end else if (!commit_write) begin
          rdata_q <= mem[commit_word];
        end
      end
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_en && commit_write && !commit_err) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_mask[i]) begin
          mem[commit_word][8*i +: 8] <= commit_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.dataMemOut = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: self-checking bench for data_mem_responder.
// Four responders with WAIT_STATES 1, 0, 15 and 4 share clock and reset; a
// word-array model per instance predicts error, latency and read data.
module tb_data_mem_responder;
  localparam int unsigned AW   = 10;
  localparam int          NDut = 4;
  // Instance k uses WsPack[4k +: 4] wait states: k0=1, k1=0, k2=15, k3=4.
  localparam logic [15:0] WsPack = {4'd4, 4'd15, 4'd0, 4'd1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        tb_req_valid [NDut];
  logic [31:0] tb_address   [NDut];
  logic        tb_read      [NDut];
  logic        tb_write     [NDut];
  logic [3:0]  tb_mask      [NDut];
  logic [31:0] tb_wdata     [NDut];
  logic        o_req_ready  [NDut];
  logic        o_rsp_valid  [NDut];
  logic        o_rsp_error  [NDut];
  logic [31:0] o_rdata      [NDut];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    data_mem_responder_if bus ();
    assign bus.req_valid = tb_req_valid[g];
    assign bus.address   = tb_address[g];
    assign bus.read      = tb_read[g];
    assign bus.write     = tb_write[g];
    assign bus.maskByte  = tb_mask[g];
    assign bus.dataMemIn = tb_wdata[g];
    assign o_req_ready[g] = bus.req_ready;
    assign o_rsp_valid[g] = bus.rsp_valid;
    assign o_rsp_error[g] = bus.rsp_error;
    assign o_rdata[g]     = bus.dataMemOut;

    data_mem_responder #(
      .ADDR_WIDTH (AW),
      .WAIT_STATES(32'(WsPack[4*g +: 4]))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  // Behavioural model: a plain word array plus the last response word.
  logic [31:0] mdl_mem [NDut][2**AW];
  logic [31:0] mdl_out [NDut];

  function automatic int ws(input int k);
    return 32'(WsPack[4*k +: 4]);
  endfunction

  function automatic void model_apply(input int k, input logic rd, input logic wr,
                                      input logic [31:0] addr, input logic [3:0] mask,
                                      input logic [31:0] data, output logic e);
    int unsigned w;
    w = addr / 4;
    e = (rd && wr) || (w >= 2**AW);
    if (e) begin
      mdl_out[k] = 32'h0;
    end else if (wr) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) mdl_mem[k][w][8*i +: 8] = data[8*i +: 8];
    end else begin
      mdl_out[k] = mdl_mem[k][w];
    end
  endfunction

  // Drives one request starting at a negedge, waits for the pulse and returns at
  // the negedge after it. busy_ok clears if req_ready is seen high while busy or
  // the pulse lasts more than one cycle. lat counts negedges from acceptance.
  task automatic do_req(input int k, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output logic busy_ok, output int acc_cyc, output logic exp_err);
    int waits = 0;
    logic got = 1'b0;
    err = 1'bx;
    rdata = 'x;
    busy_ok = 1'b1;
    exp_err = 1'bx;
    lat = 0;
    acc_cyc = -1;
    tb_req_valid[k] = 1'b1;
    tb_read[k] = rd;
    tb_write[k] = wr;
    tb_address[k] = addr;
    tb_mask[k] = mask;
    tb_wdata[k] = data;
    while (!o_req_ready[k] && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!o_req_ready[k]) begin
      tb_req_valid[k] = 1'b0;
      lat = 999;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    model_apply(k, rd, wr, addr, mask, data, exp_err);
    #1;
    // Scramble request inputs; the responder must have captured them already.
    tb_req_valid[k] = 1'b0;
    tb_read[k] = 1'($urandom);
    tb_write[k] = 1'($urandom);
    tb_address[k] = {20'h0, 12'($urandom)};
    tb_mask[k] = 4'($urandom);
    tb_wdata[k] = $urandom;
    while (lat < 40 && !got) begin
      @(negedge clk);
      lat++;
      if (o_rsp_valid[k]) got = 1'b1;
      if (o_req_ready[k]) busy_ok = 1'b0;
    end
    if (!got) begin
      lat = 999;
      return;
    end
    err = o_rsp_error[k];
    rdata = o_rdata[k];
    @(negedge clk);
    if (o_rsp_valid[k] || !o_req_ready[k]) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NDut; k++) begin
      tb_req_valid[k] = 1'b0;
      tb_read[k] = 1'b0;
      tb_write[k] = 1'b0;
      tb_address[k] = '0;
      tb_mask[k] = '0;
      tb_wdata[k] = '0;
      mdl_out[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDut; k++) begin
      checks += 4;
      if (o_req_ready[k] !== 1'b1) begin
        failures++; $display("FAIL reset_ready k=%0d got=%b want=1", k, o_req_ready[k]);
      end
      if (o_rsp_valid[k] !== 1'b0) begin
        failures++; $display("FAIL reset_valid k=%0d got=%b want=0", k, o_rsp_valid[k]);
      end
      if (o_rsp_error[k] !== 1'b0) begin
        failures++; $display("FAIL reset_error k=%0d got=%b want=0", k, o_rsp_error[k]);
      end
      if (o_rdata[k] !== 32'h0) begin
        failures++; $display("FAIL reset_rdata k=%0d got=%h want=0", k, o_rdata[k]);
      end
    end
  endtask

  task automatic test_basic();
    int lat, acc;
    logic err, busy, ee;
    logic [31:0] rd;
    do_req(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, err, rd, busy, acc, ee);
    checks += 3;
    if (lat !== 2) begin failures++; $display("FAIL basic_wr_lat got=%0d want=2", lat); end
    if (err !== 1'b0) begin failures++; $display("FAIL basic_wr_err got=%b want=0", err); end
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_wr_ready got=%b want=1", busy); end
    do_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, err, rd, busy, acc, ee);
    checks += 2;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL basic_rd_data got=%h want=deadbeef", rd);
    end
    if (err !== 1'b0) begin failures++; $display("FAIL basic_rd_err got=%b want=0", err); end
  endtask

  task automatic test_byte_mask();
    int lat, acc;
    logic err, busy, ee;
    logic [31:0] rd;
    do_req(0, 1'b0, 1'b1, 32'h40, 4'hF, 32'h11223344, lat, err, rd, busy, acc, ee);
    do_req(0, 1'b0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, lat, err, rd, busy, acc, ee);
    do_req(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, err, rd, busy, acc, ee);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++; $display("FAIL mask_0101 got=%h want=11bb33dd", rd);
    end
    do_req(0, 1'b0, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, lat, err, rd, busy, acc, ee);
    checks += 2;
    if (err !== 1'b0 || lat !== 2) begin
      failures++; $display("FAIL mask_0000_rsp got=err%b/lat%0d want=err0/lat2", err, lat);
    end
    if (rd !== 32'h11BB33DD) begin
      failures++; $display("FAIL mask_0000_hold got=%h want=11bb33dd", rd);
    end
    do_req(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, err, rd, busy, acc, ee);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++; $display("FAIL mask_0000_ram got=%h want=11bb33dd", rd);
    end
  endtask

  task automatic test_errors();
    int lat, acc, seen_valid, seen_busy;
    logic err, busy, ee;
    logic [31:0] rd;
    do_req(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, lat, err, rd, busy, acc, ee);
    checks += 2;
    if (err !== 1'b1) begin failures++; $display("FAIL err_range got=%b want=1", err); end
    if (rd !== 32'h0) begin failures++; $display("FAIL err_range_data got=%h want=0", rd); end
    do_req(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0, lat, err, rd, busy, acc, ee);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_rdwr got=%b want=1", err); end
    do_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, err, rd, busy, acc, ee);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL err_rdwr_ram got=%h want=deadbeef", rd);
    end
    do_req(0, 1'b0, 1'b1, 32'hFFC, 4'hF, 32'h5A5A1234, lat, err, rd, busy, acc, ee);
    do_req(0, 1'b1, 1'b0, 32'hFFC, 4'h0, 32'h0, lat, err, rd, busy, acc, ee);
    checks++;
    if (err !== 1'b0 || rd !== 32'h5A5A1234) begin
      failures++; $display("FAIL top_word got=err%b/%h want=err0/5a5a1234", err, rd);
    end
    // req_valid without read or write must be ignored.
    tb_req_valid[0] = 1'b1;
    tb_read[0] = 1'b0;
    tb_write[0] = 1'b0;
    tb_address[0] = 32'h10;
    seen_valid = 0;
    seen_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_rsp_valid[0]) seen_valid++;
      if (!o_req_ready[0]) seen_busy++;
    end
    tb_req_valid[0] = 1'b0;
    checks += 2;
    if (seen_valid !== 0) begin failures++; $display("FAIL noop_rsp got=%0d want=0", seen_valid); end
    if (seen_busy !== 0) begin failures++; $display("FAIL noop_busy got=%0d want=0", seen_busy); end
  endtask

  task automatic test_back_to_back();
    int lat, acc_w, acc_r;
    logic err, busy, ee;
    logic [31:0] rd, wd;
    for (int k = 0; k < NDut; k++) begin
      @(negedge clk);
      wd = $urandom;
      do_req(k, 1'b0, 1'b1, 32'h200, 4'hF, wd, lat, err, rd, busy, acc_w, ee);
      checks += 2;
      if (lat !== ws(k) + 1) begin
        failures++; $display("FAIL b2b_lat k=%0d got=%0d want=%0d", k, lat, ws(k) + 1);
      end
      if (busy !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%b want=1", k, busy); end
      do_req(k, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0, lat, err, rd, busy, acc_r, ee);
      checks += 2;
      if (acc_r - acc_w !== ws(k) + 2) begin
        failures++; $display("FAIL b2b_period k=%0d got=%0d want=%0d", k, acc_r - acc_w, ws(k) + 2);
      end
      if (rd !== wd) begin failures++; $display("FAIL b2b_data k=%0d got=%h want=%h", k, rd, wd); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, acc, pulses;
    logic err, busy, ee;
    logic [31:0] rd;
    @(negedge clk);
    do_req(3, 1'b0, 1'b1, 32'h80, 4'hF, 32'h0BADF00D, lat, err, rd, busy, acc, ee);
    tb_req_valid[3] = 1'b1;
    tb_read[3] = 1'b0;
    tb_write[3] = 1'b1;
    tb_address[3] = 32'h80;
    tb_mask[3] = 4'hF;
    tb_wdata[3] = 32'h12345678;
    @(posedge clk);
    #1 tb_req_valid[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDut; k++) mdl_out[k] = '0;
    checks += 2;
    if (o_rsp_valid[3] !== 1'b0 || o_req_ready[3] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async got=valid%b/ready%b want=valid0/ready1",
               o_rsp_valid[3], o_req_ready[3]);
    end
    if (o_rdata[3] !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%h want=0", o_rdata[3]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_rsp_valid[3]) pulses++;
    end
    checks += 2;
    if (pulses !== 0) begin failures++; $display("FAIL rstmid_pulse got=%0d want=0", pulses); end
    if (o_req_ready[3] !== 1'b1) begin
      failures++; $display("FAIL rstmid_ready got=%b want=1", o_req_ready[3]);
    end
    do_req(3, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0, lat, err, rd, busy, acc, ee);
    checks++;
    if (rd !== 32'h0BADF00D) begin
      failures++; $display("FAIL rstmid_old got=%h want=0badf00d", rd);
    end
  endtask

  task automatic test_random();
    int lat, acc, sel;
    logic err, busy, ee, rdo, wro;
    logic [31:0] rd, addr;
    logic [3:0] mask;
    logic [31:0] pool [6];
    for (int k = 0; k < NDut; k++) begin
      @(negedge clk);
      for (int j = 0; j < 6; j++) begin
        pool[j] = (j == 5) ? 32'h0000_0FFC : 32'($urandom_range(0, 2**AW - 1)) * 4;
        do_req(k, 1'b0, 1'b1, pool[j], 4'hF, $urandom, lat, err, rd, busy, acc, ee);
      end
      for (int n = 0; n < 25; n++) begin
        sel = $urandom_range(0, 9);
        addr = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
        mask = 4'($urandom);
        rdo = (sel != 2 && sel != 3 && sel != 4 && sel != 5);
        wro = !rdo || sel == 1;
        if (sel == 0) addr = 32'h1000 + $urandom_range(0, 32'h0FFF_0000);
        do_req(k, rdo, wro, addr, mask, $urandom, lat, err, rd, busy, acc, ee);
        checks += 3;
        if (lat !== ws(k) + 1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL rand_timing k=%0d n=%0d got=lat%0d/busy%b want=lat%0d/busy1",
                   k, n, lat, busy, ws(k) + 1);
        end
        if (err !== ee) begin
          failures++; $display("FAIL rand_err k=%0d n=%0d got=%b want=%b", k, n, err, ee);
        end
        if (rd !== mdl_out[k]) begin
          failures++; $display("FAIL rand_data k=%0d n=%0d got=%h want=%h", k, n, rd, mdl_out[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
